// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-client SDRAM command arbiter.
// Address layout is {bank, row, col}, matching the controller's word address.
package sdram_arb_pkg;

    localparam int BANK_W     = 2;
    localparam int ROW_W      = 12;
    localparam int COL_W      = 8;
    localparam int ADDR_W_DEF = BANK_W + ROW_W + COL_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        XFER = 2'd2,
        REF  = 2'd3
    } state_t;

    // Round-robin pick: on a tie the client not served last wins.
    function automatic logic pick_client(input logic [1:0] req, input logic last_srv);
        return (&req) ? ~last_srv : req[1];
    endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Free-running refresh interval timer; raises ref_pend on each wrap, held until ref_ack.
// A wrap while ref_pend is already set is absorbed rather than queued.
module sdram_ref_timer #(
    parameter int REF_PERIOD = 780
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ref_ack,
    output logic ref_pend
);

    localparam int CNT_W = $clog2(REF_PERIOD + 1);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap = (cnt == CNT_W'(REF_PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            ref_pend <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + CNT_W'(1);
            if (ref_ack)
                ref_pend <= 1'b0;
            else if (wrap)
                ref_pend <= 1'b1;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares the SDRAM controller's write/read command ports between two burst clients, with refresh
// taking priority at IDLE. Command issues one cycle after a request is seen; clients wait on req/ack.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int BURST_LEN  = 256,
    parameter int REF_PERIOD = 780
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          cli_req,
    input  logic [1:0]          cli_wr,
    input  logic [2*ADDR_W-1:0] cli_addr,
    output logic [1:0]          cli_ack,
    output logic [1:0]          grant,
    output logic                sd_wr_req,
    output logic [ADDR_W-1:0]   sd_waddr,
    input  logic                sd_wr_ack,
    output logic                sd_rd_req,
    output logic [ADDR_W-1:0]   sd_raddr,
    input  logic                sd_rd_ack,
    output logic                sd_ref_req,
    input  logic                sd_ref_ack,
    output logic                busy
);

    localparam int BCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    state_t            state;
    logic              sel;
    logic              wr_lat;
    logic              last_srv;
    logic [BCNT_W-1:0] bcnt;
    logic              ref_pend;
    logic              ref_ack;
    logic              win;
    logic [ADDR_W-1:0] win_addr;

    assign ref_ack  = (state == REF) && sd_ref_ack;
    assign win      = pick_client(cli_req, last_srv);
    assign win_addr = win ? cli_addr[2*ADDR_W-1:ADDR_W] : cli_addr[ADDR_W-1:0];

    sdram_ref_timer #(.REF_PERIOD(REF_PERIOD)) u_ref_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .ref_ack  (ref_ack),
        .ref_pend (ref_pend)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= 1'b0;
            wr_lat     <= 1'b0;
            last_srv   <= 1'b1;
            bcnt       <= '0;
            cli_ack    <= '0;
            grant      <= '0;
            sd_wr_req  <= 1'b0;
            sd_rd_req  <= 1'b0;
            sd_waddr   <= '0;
            sd_raddr   <= '0;
            sd_ref_req <= 1'b0;
            busy       <= 1'b0;
        end else begin
            cli_ack <= '0;
            case (state)
                IDLE: begin
                    if (ref_pend) begin
                        sd_ref_req <= 1'b1;
                        busy       <= 1'b1;
                        state      <= REF;
                    end else if (|cli_req) begin
                        sel       <= win;
                        wr_lat    <= cli_wr[win];
                        sd_waddr  <= win_addr;
                        sd_raddr  <= win_addr;
                        sd_wr_req <= cli_wr[win];
                        sd_rd_req <= ~cli_wr[win];
                        busy      <= 1'b1;
                        state     <= CMD;
                    end
                end
                CMD: begin
                    // Only the ack matching the issued direction commits the command.
                    if (wr_lat ? sd_wr_ack : sd_rd_ack) begin
                        sd_wr_req    <= 1'b0;
                        sd_rd_req    <= 1'b0;
                        cli_ack[sel] <= 1'b1;
                        grant[sel]   <= 1'b1;
                        bcnt         <= '0;
                        state        <= XFER;
                    end
                end
                XFER: begin
                    if (bcnt == BCNT_W'(BURST_LEN - 1)) begin
                        grant    <= '0;
                        last_srv <= sel;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        bcnt <= bcnt + BCNT_W'(1);
                    end
                end
                REF: begin
                    if (sd_ref_ack) begin
                        sd_ref_req <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed scenarios plus randomized traffic, checked cycle by cycle against a transaction-level model.
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;

    localparam int AW = ADDR_W_DEF;
    localparam int BL = 256;
    localparam int RP = 780;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      cli_req, cli_wr, cli_ack, grant;
    logic [2*AW-1:0] cli_addr;
    logic            sd_wr_req, sd_wr_ack, sd_rd_req, sd_rd_ack, sd_ref_req, sd_ref_ack, busy;
    logic [AW-1:0]   sd_waddr, sd_raddr;

    always #5 clk = ~clk;

    sdram_arbiter #(.ADDR_W(AW), .BURST_LEN(BL), .REF_PERIOD(RP)) dut (
        .clk(clk), .rst_n(rst_n),
        .cli_req(cli_req), .cli_wr(cli_wr), .cli_addr(cli_addr), .cli_ack(cli_ack),
        .grant(grant),
        .sd_wr_req(sd_wr_req), .sd_waddr(sd_waddr), .sd_wr_ack(sd_wr_ack),
        .sd_rd_req(sd_rd_req), .sd_raddr(sd_raddr), .sd_rd_ack(sd_rd_ack),
        .sd_ref_req(sd_ref_req), .sd_ref_ack(sd_ref_ack),
        .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: who holds the command port, how many burst cycles remain, refresh owed.
    int            m_tick, m_cmd, m_left, m_owner, m_last;
    bit            m_pend, m_cmd_wr;
    logic          e_wr, e_rd, e_ref, e_busy;
    logic [1:0]    e_ack, e_grant;
    logic [AW-1:0] e_waddr, e_raddr;

    task automatic model_reset();
        m_tick = 0; m_pend = 0; m_cmd = -1; m_cmd_wr = 0; m_left = 0; m_owner = 0; m_last = 1;
        e_wr = 0; e_rd = 0; e_ref = 0; e_busy = 0; e_ack = 0; e_grant = 0; e_waddr = 0; e_raddr = 0;
    endtask

    task automatic model_edge();
        bit wrap, ref_done;
        int w;
        wrap     = ((m_tick % RP) == RP - 1);
        ref_done = e_ref && sd_ref_ack;
        m_tick++;
        e_ack = 2'b00;
        if (e_ref) begin
            if (sd_ref_ack) e_ref = 0;
        end else if (m_cmd >= 0) begin
            if (m_cmd_wr ? sd_wr_ack : sd_rd_ack) begin
                e_wr = 0; e_rd = 0;
                e_ack[m_cmd] = 1'b1;
                e_grant[m_cmd] = 1'b1;
                m_owner = m_cmd; m_left = BL; m_cmd = -1;
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                e_grant = 2'b00;
                m_last = m_owner;
            end
        end else if (m_pend) begin
            e_ref = 1;
        end else if (cli_req != 2'b00) begin
            w = (cli_req == 2'b11) ? 1 - m_last : (cli_req[1] ? 1 : 0);
            m_cmd = w; m_cmd_wr = cli_wr[w];
            e_waddr = cli_addr[w*AW +: AW]; e_raddr = e_waddr;
            e_wr = cli_wr[w]; e_rd = !cli_wr[w];
        end
        m_pend = ref_done ? 1'b0 : (m_pend | wrap);
        e_busy = e_ref || (m_cmd >= 0) || (m_left > 0);
    endtask

    // Stimulus controls and monitors
    bit         rnd_mode, hold;
    int         cmd_wait, cmd_dly, ref_wait, ref_dly;
    logic [1:0] grant_log[$];
    int         ev_log[$];
    int         ref_rises, g0_cyc, ack0_cnt;
    logic [1:0] prev_grant;
    logic       prev_ref;
    logic [AW-1:0] last_raddr;

    function automatic int q_at(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    task automatic new_txn(input int i);
        cli_req[i] = 1'b1;
        cli_wr[i]  = 1'($urandom);
        cli_addr[i*AW +: AW] = AW'($urandom);
    endtask

    task automatic drive_ctrl();
        sd_wr_ack = 0; sd_rd_ack = 0; sd_ref_ack = 0;
        if (e_wr || e_rd) begin
            if (cmd_wait >= cmd_dly) begin
                sd_wr_ack = e_wr; sd_rd_ack = e_rd;
                cmd_wait = 0;
                cmd_dly = rnd_mode ? int'($urandom_range(0, 4)) : 3;
            end else begin
                cmd_wait++;
                if (rnd_mode && $urandom_range(0, 3) == 0) begin
                    sd_wr_ack = e_rd; sd_rd_ack = e_wr;
                end
            end
        end
        if (e_ref) begin
            if (ref_wait >= ref_dly) begin
                sd_ref_ack = 1;
                ref_wait = 0;
                if (rnd_mode) ref_dly = $urandom_range(0, 6);
            end else begin
                ref_wait++;
            end
        end
    endtask

    task automatic drive_clients();
        for (int i = 0; i < 2; i++) begin
            if (e_ack[i]) begin
                if (rnd_mode && $urandom_range(0, 1) == 0) new_txn(i);
                else if (!hold) cli_req[i] = 1'b0;
            end else if (rnd_mode && !cli_req[i] && $urandom_range(0, 15) == 0) begin
                new_txn(i);
            end else if (rnd_mode && m_cmd == i && $urandom_range(0, 15) == 0) begin
                cli_req[i] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        drive_ctrl();
        drive_clients();
        @(negedge clk);
        check_val("cycle_outputs",
                  {cli_ack, grant, sd_wr_req, sd_rd_req, sd_ref_req, busy, sd_waddr, sd_raddr},
                  {e_ack, e_grant, e_wr, e_rd, e_ref, e_busy, e_waddr, e_raddr});
        if (grant != 2'b00 && prev_grant == 2'b00) begin
            grant_log.push_back(grant);
            ev_log.push_back(int'(grant));
        end
        if (sd_ref_req && !prev_ref) begin
            ref_rises++;
            ev_log.push_back(3);
        end
        if (grant == 2'b01) g0_cyc++;
        if (cli_ack[0]) ack0_cnt++;
        if (sd_rd_req) last_raddr = sd_raddr;
        prev_grant = grant;
        prev_ref   = sd_ref_req;
    endtask

    task automatic do_reset();
        rst_n = 0;
        cli_req = 0; cli_wr = 0; cli_addr = 0;
        sd_wr_ack = 0; sd_rd_ack = 0; sd_ref_ack = 0;
        rnd_mode = 0; hold = 0;
        cmd_wait = 0; cmd_dly = 3; ref_wait = 0; ref_dly = 2;
        grant_log.delete(); ev_log.delete();
        ref_rises = 0; g0_cyc = 0; ack0_cnt = 0;
        prev_grant = 0; prev_ref = 0; last_raddr = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    logic [AW-1:0] t1_addr;
    int            k;

    initial begin
        do_reset();
        check_val("reset_outputs",
                  {cli_ack, grant, sd_wr_req, sd_rd_req, sd_ref_req, busy, sd_waddr, sd_raddr}, 64'd0);

        // Single write from client 0
        t1_addr = {2'd1, 12'd5, 8'd0};
        cli_req[0] = 1; cli_wr[0] = 1; cli_addr[AW-1:0] = t1_addr;
        step();
        check_val("t1_wr_req_latency", sd_wr_req, 1);
        check_val("t1_waddr", sd_waddr, t1_addr);
        repeat (300) step();
        check_val("t1_grant_cycles", g0_cyc, BL);
        check_val("t1_ack_pulses", ack0_cnt, 1);
        check_val("t1_busy_end", busy, 0);

        // Simultaneous requests after reset: client 0 first
        do_reset();
        cli_req = 2'b11; cli_wr = 2'b01;
        cli_addr = {22'h020000, 22'h003a10};
        k = 0;
        while (grant_log.size() < 2 && k < 1000) begin step(); k++; end
        check_val("t2_grant_count", grant_log.size(), 2);
        check_val("t2_first", q_at(ev_log, 0), 1);
        check_val("t2_second", q_at(ev_log, 1), 2);
        check_val("t2_raddr", last_raddr, 22'h020000);

        // Fairness with both clients holding requests
        do_reset();
        hold = 1;
        cli_req = 2'b11; cli_wr = 2'b10;
        k = 0;
        while (grant_log.size() < 4 && k < 2000) begin step(); k++; end
        check_val("t3_g0", grant_log.size() > 0 ? grant_log[0] : 2'b00, 2'b01);
        check_val("t3_g1", grant_log.size() > 1 ? grant_log[1] : 2'b00, 2'b10);
        check_val("t3_g2", grant_log.size() > 2 ? grant_log[2] : 2'b00, 2'b01);
        check_val("t3_g3", grant_log.size() > 3 ? grant_log[3] : 2'b00, 2'b10);

        // Refresh wrap during a burst while client 1 waits
        do_reset();
        repeat (600) step();
        cli_req[0] = 1; cli_wr[0] = 1;
        repeat (100) step();
        cli_req[1] = 1; cli_wr[1] = 0;
        k = 0;
        while (ev_log.size() < 3 && k < 1000) begin step(); k++; end
        check_val("t4_ev0_client0", q_at(ev_log, 0), 1);
        check_val("t4_ev1_refresh", q_at(ev_log, 1), 3);
        check_val("t4_ev2_client1", q_at(ev_log, 2), 2);

        // Refresh ack withheld across a second wrap
        do_reset();
        ref_dly = 1000;
        repeat (2200) step();
        check_val("t5_ref_episodes", ref_rises, 1);
        check_val("t5_ref_idle", sd_ref_req, 0);

        // Randomized traffic
        do_reset();
        rnd_mode = 1;
        ref_dly = 3;
        repeat (25000) step();
        rnd_mode = 0;

        // Reset during a burst
        do_reset();
        cli_req[0] = 1; cli_wr[0] = 0;
        k = 0;
        while (grant == 2'b00 && k < 50) begin step(); k++; end
        check_val("t7_grant_up", grant, 2'b01);
        repeat (100) step();
        rst_n = 0;
        #1;
        check_val("t7_async_clear", {grant, busy, sd_wr_req, sd_rd_req, sd_ref_req, cli_ack}, 0);
        do_reset();
        cli_req = 2'b11; cli_wr = 2'b11;
        k = 0;
        while (grant_log.size() < 1 && k < 50) begin step(); k++; end
        check_val("t7_tie_after_reset", grant_log.size() > 0 ? grant_log[0] : 2'b00, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
